// File: rtl/cla_add_pipe.sv
// Pipelined two-level carry-lookahead adder/subtractor with valid/ready handshake.
// S1: operand conditioning and bit g/p. S2: 4-bit group lookahead plus a
// second 4-wide lookahead across groups. S3: sum, carry-out, overflow.
module cla_add_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic [TAG_W-1:0] out_tag
);

    localparam int NG = WIDTH / 4;    // 4-bit groups
    localparam int NS = (NG + 3) / 4; // supergroups of up to 4 groups

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 8 || WIDTH > 64) begin : g_bad_width
            $error("cla_add_pipe: WIDTH must be a multiple of 4 in 8..64");
        end
        if (TAG_W < 1) begin : g_bad_tag
            $error("cla_add_pipe: TAG_W must be at least 1");
        end
    endgenerate

    // 4-wide lookahead: c[0] is the block carry-in, c[1..3] internal carries,
    // c[4] the block carry-out.
    function automatic logic [4:0] la4(input logic [3:0] g, input logic [3:0] p,
                                       input logic ci);
        logic [4:0] c;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | ((&p) & ci);
        return c;
    endfunction

    logic en;
    logic v1, v2, v3;

    // Stage 1 registers
    logic [WIDTH-1:0] g1, p1;
    logic             c0_1;
    logic [TAG_W-1:0] tag1;

    // Stage 2 registers
    logic [WIDTH-1:0]       p2;
    logic [NG-1:0][3:1]     cz2;  // internal group carries assuming group carry-in 0
    logic [NG-1:0][3:1]     co2;  // internal group carries assuming group carry-in 1
    logic [NG:0]            cg2;  // carry into each group; cg2[NG] is carry-out
    logic [TAG_W-1:0]       tag2;

    // Stage 2 combinational
    logic [4*NS-1:0]        gg, gp;
    logic [3:0]             sg, sp;
    logic [4:0]             sc;
    logic [4:0]             la;
    logic [4*NS:0]          cg_c;
    logic [NG-1:0][3:1]     cz_c, co_c;

    // Stage 3 combinational
    logic [WIDTH-1:0]       cv;

    assign en       = ~v3 | out_ready;
    assign in_ready = en;
    assign out_valid = v3;

    // Stage-valid flags: cleared by reset, shifted together when the pipe advances
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else if (en) begin
            v1 <= in_valid;
            v2 <= v1;
            v3 <= v2;
        end
    end

    // Stage 1 data: condition operand B and form bit generate/propagate
    always_ff @(posedge clk) begin
        if (en) begin
            g1   <= in_a & (in_sub ? ~in_b : in_b);
            p1   <= in_a ^ (in_sub ? ~in_b : in_b);
            c0_1 <= in_sub | in_cin;
            tag1 <= in_tag;
        end
    end

    // Group lookahead, then supergroup lookahead, then carries into every group
    always_comb begin
        gg   = '0;
        gp   = '0;
        sg   = '0;
        sp   = '0;
        la   = '0;
        cz_c = '0;
        co_c = '0;
        cg_c = '0;
        for (int unsigned k = 0; k < NG; k++) begin
            la       = la4(g1[4*k +: 4], p1[4*k +: 4], 1'b0);
            gg[k]    = la[4];
            gp[k]    = &p1[4*k +: 4];
            cz_c[k]  = la[3:1];
            co_c[k][1] = la[1] | p1[4*k];
            co_c[k][2] = la[2] | (&p1[4*k +: 2]);
            co_c[k][3] = la[3] | (&p1[4*k +: 3]);
        end
        for (int unsigned s = 0; s < NS; s++) begin
            la    = la4(gg[4*s +: 4], gp[4*s +: 4], 1'b0);
            sg[s] = la[4];
            sp[s] = &gp[4*s +: 4];
        end
        sc = la4(sg, sp, c0_1);
        for (int unsigned s = 0; s < NS; s++) begin
            la             = la4(gg[4*s +: 4], gp[4*s +: 4], sc[s]);
            cg_c[4*s +: 4] = la[3:0];
        end
        cg_c[4*NS] = sc[NS];
    end

    // Stage 2 data: register propagate, both internal-carry variants and group carries
    always_ff @(posedge clk) begin
        if (en) begin
            p2   <= p1;
            cz2  <= cz_c;
            co2  <= co_c;
            cg2  <= cg_c[NG:0];
            tag2 <= tag1;
        end
    end

    // Select each bit's carry from its group carry-in and the matching variant
    always_comb begin
        cv = '0;
        for (int unsigned k = 0; k < NG; k++) begin
            cv[4*k] = cg2[k];
            for (int unsigned j = 1; j < 4; j++) begin
                cv[4*k + j] = cg2[k] ? co2[k][j] : cz2[k][j];
            end
        end
    end

    // Output stage: cleared by reset, held while stalled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_sum  <= '0;
            out_cout <= 1'b0;
            out_ovf  <= 1'b0;
            out_tag  <= '0;
        end else if (en) begin
            out_sum  <= p2 ^ cv;
            out_cout <= cg2[NG];
            out_ovf  <= cv[WIDTH-1] ^ cg2[NG];
            out_tag  <= tag2;
        end
    end

endmodule

// File: tb/tb_cla_add_pipe.sv
// Self-checking bench: three adder widths driven in lockstep, checked against
// an arithmetic reference model and a three-slot pipeline occupancy model.
module tb_cla_add_pipe;

    localparam int TW = 4;

    typedef struct packed {
        logic [63:0]   a;
        logic [63:0]   b;
        logic          cin;
        logic          sub;
        logic [TW-1:0] tag;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, in_valid, out_ready, in_cin, in_sub;
    logic [63:0]   in_a, in_b;
    logic [TW-1:0] in_tag;

    logic          rdy16, vld16, cout16, ovf16;
    logic [15:0]   sum16;
    logic [TW-1:0] tag16;
    logic          rdy32, vld32, cout32, ovf32;
    logic [31:0]   sum32;
    logic [TW-1:0] tag32;
    logic          rdy64, vld64, cout64, ovf64;
    logic [63:0]   sum64;
    logic [TW-1:0] tag64;

    cla_add_pipe #(.WIDTH(16), .TAG_W(TW)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy16),
        .in_a(in_a[15:0]), .in_b(in_b[15:0]), .in_cin(in_cin), .in_sub(in_sub),
        .in_tag(in_tag), .out_valid(vld16), .out_ready(out_ready),
        .out_sum(sum16), .out_cout(cout16), .out_ovf(ovf16), .out_tag(tag16));

    cla_add_pipe #(.WIDTH(32), .TAG_W(TW)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32),
        .in_a(in_a[31:0]), .in_b(in_b[31:0]), .in_cin(in_cin), .in_sub(in_sub),
        .in_tag(in_tag), .out_valid(vld32), .out_ready(out_ready),
        .out_sum(sum32), .out_cout(cout32), .out_ovf(ovf32), .out_tag(tag32));

    cla_add_pipe #(.WIDTH(64), .TAG_W(TW)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy64),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
        .in_tag(in_tag), .out_valid(vld64), .out_ready(out_ready),
        .out_sum(sum64), .out_cout(cout64), .out_ovf(ovf64), .out_tag(tag64));

    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    int    pops     = 0;
    logic  prev_rst;
    logic [2:0] mv;          // expected stage occupancy, mv[2] = output stage
    beat_t sb[$];            // beats in flight, oldest first
    logic [15:0]   last_sum16;
    logic          last_cout16, last_ovf16;
    logic [TW-1:0] last_tag16;

    task automatic check_eq(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference result {ovf, cout, sum} from plain integer arithmetic
    function automatic logic [65:0] ref_calc(input int unsigned w, input beat_t t);
        logic [64:0] mask, am, bm, r;
        logic        sa, sb_, sr, cout, ovf;
        mask = (65'd1 << w) - 65'd1;
        am   = {1'b0, t.a} & mask;
        bm   = {1'b0, t.b} & mask;
        sa   = am[w-1];
        sb_  = bm[w-1];
        if (t.sub) begin
            r    = (am - bm) & mask;
            cout = (am >= bm);
            sr   = r[w-1];
            ovf  = (sa != sb_) && (sr != sa);
        end else begin
            r    = am + bm + {64'd0, t.cin};
            cout = r[w];
            r    = r & mask;
            sr   = r[w-1];
            ovf  = (sa == sb_) && (sr != sa);
        end
        return {ovf, cout, r[63:0]};
    endfunction

    task automatic check_dut(input string nm, input int unsigned w, input logic [63:0] sum,
                             input logic cout, input logic ovf, input logic [TW-1:0] tag,
                             input beat_t t);
        logic [65:0] r;
        r = ref_calc(w, t);
        check_eq({nm, "_sum"}, sum, r[63:0]);
        check_eq({nm, "_cout"}, cout, r[64]);
        check_eq({nm, "_ovf"}, ovf, r[65]);
        check_eq({nm, "_tag"}, tag, t.tag);
    endtask

    // One clock cycle: drive at the falling edge, check 1 time unit later
    task automatic cycle(input logic iv, input logic ordy, input logic rstn, input beat_t t);
        logic exp_rdy, acc, pop;
        rst_n = rstn; in_valid = iv; out_ready = ordy;
        in_a = t.a; in_b = t.b; in_cin = t.cin; in_sub = t.sub; in_tag = t.tag;
        #1;
        exp_rdy = ~mv[2] | ordy;
        if (prev_rst) begin
            check_eq("rst_out16", {vld16, cout16, ovf16, tag16, sum16}, '0);
            check_eq("rst_out32", {vld32, cout32, ovf32, tag32, sum32}, '0);
            check_eq("rst_out64", {vld64, cout64, ovf64, tag64, sum64}, '0);
        end
        check_eq("valid16", vld16, mv[2]);
        check_eq("valid32", vld32, mv[2]);
        check_eq("valid64", vld64, mv[2]);
        check_eq("ready16", rdy16, exp_rdy);
        check_eq("ready32", rdy32, exp_rdy);
        check_eq("ready64", rdy64, exp_rdy);
        if (mv[2] && sb.size() > 0) begin
            check_dut("w16", 16, {48'd0, sum16}, cout16, ovf16, tag16, sb[0]);
            check_dut("w32", 32, {32'd0, sum32}, cout32, ovf32, tag32, sb[0]);
            check_dut("w64", 64, sum64, cout64, ovf64, tag64, sb[0]);
        end
        acc = iv & exp_rdy & rstn;
        pop = mv[2] & ordy;
        if (pop) begin
            last_sum16  = sum16;
            last_cout16 = cout16;
            last_ovf16  = ovf16;
            last_tag16  = tag16;
            pops++;
            if (sb.size() > 0) void'(sb.pop_front());
        end
        if (!rstn) begin
            sb.delete();
            mv       = '0;
            prev_rst = 1'b1;
        end else begin
            prev_rst = 1'b0;
            if (acc) sb.push_back(t);
            if (exp_rdy) mv = {mv[1:0], acc};
        end
        @(negedge clk);
        cyc++;
    endtask

    function automatic beat_t rnd_beat();
        beat_t t;
        t.a   = {$urandom, $urandom};
        t.b   = {$urandom, $urandom};
        t.cin = 1'($urandom_range(0, 1));
        t.sub = 1'($urandom_range(0, 1));
        t.tag = TW'($urandom);
        case ($urandom_range(0, 5))
            0: t.b = ~t.a;                     // full propagate chain
            1: begin t.a = '1; t.b = '0; end   // carry ripples through every group
            2: t.b = t.a;                      // zero difference on subtract
            default: ;
        endcase
        return t;
    endfunction

    function automatic beat_t mk(input logic [63:0] a, input logic [63:0] b,
                                 input logic cin, input logic sub, input logic [TW-1:0] tag);
        beat_t t;
        t.a = a; t.b = b; t.cin = cin; t.sub = sub; t.tag = tag;
        return t;
    endfunction

    // Single beat into an idle pipe, then fixed 16-bit expectations
    task automatic directed(input string nm, input beat_t t, input logic [15:0] es,
                            input logic ec, input logic eo);
        int p0;
        p0 = pops;
        cycle(1'b1, 1'b1, 1'b1, t);
        for (int i = 0; i < 10 && pops == p0; i++) cycle(1'b0, 1'b1, 1'b1, rnd_beat());
        check_eq({nm, "_done"}, pops - p0, 1);
        check_eq({nm, "_sum"}, last_sum16, es);
        check_eq({nm, "_cout"}, last_cout16, ec);
        check_eq({nm, "_ovf"}, last_ovf16, eo);
        check_eq({nm, "_tag"}, last_tag16, t.tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        beat_t idle;
        idle = mk('0, '0, 1'b0, 1'b0, '0);
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0; in_tag = '0;
        mv = '0;
        @(posedge clk);
        @(negedge clk);
        prev_rst = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, idle);
        cycle(1'b0, 1'b0, 1'b1, idle);

        directed("add_ovf",  mk(64'h7FFF, 64'h0001, 1'b0, 1'b0, 4'd3), 16'h8000, 1'b0, 1'b1);
        directed("sub_borrow", mk(64'h0005, 64'h0007, 1'b0, 1'b1, 4'd5), 16'hFFFE, 1'b0, 1'b0);
        directed("sub_ovf",  mk(64'h8000, 64'h0001, 1'b0, 1'b1, 4'd6), 16'h7FFF, 1'b1, 1'b1);
        directed("chain",    mk(64'hFFFF, 64'h0000, 1'b1, 1'b0, 4'd7), 16'h0000, 1'b1, 1'b0);

        // Back-to-back stream with the sink always ready
        for (int i = 0; i < 100; i++) cycle(1'b1, 1'b1, 1'b1, rnd_beat());
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b1, idle);

        // Random source and sink pressure
        for (int i = 0; i < 400; i++)
            cycle(($urandom_range(0, 99) < 70), 1'($urandom_range(0, 1)), 1'b1, rnd_beat());
        for (int i = 0; i < 20 && sb.size() > 0; i++) cycle(1'b0, 1'b1, 1'b1, idle);
        check_eq("drain_empty", sb.size(), 0);

        // Reset with three beats in flight; nothing may emerge afterwards
        cycle(1'b1, 1'b1, 1'b1, rnd_beat());
        cycle(1'b1, 1'b1, 1'b1, rnd_beat());
        cycle(1'b1, 1'b1, 1'b0, rnd_beat());
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b1, idle);
        directed("post_rst", mk(64'h1234, 64'h4321, 1'b1, 1'b0, 4'd9), 16'h5556, 1'b0, 1'b0);

        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b1, idle);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cla_add_pipe.md
Name: cla_add_pipe

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor. Successor to the team's 4-bit group generate/propagate cell.
- Structure: bit-level g/p, then 4-bit group lookahead (gp4-equivalent logic, instantiated or inlined), then a second lookahead level across groups, then the sum.
- Three register stages with a valid/ready handshake, so it drops into the datapath's streaming pipelines without further timing work.
- Supports add or subtract per beat, with carry-out, signed overflow and a pass-through tag.

Parameters:
- WIDTH, 32, operand width in bits. Must be a multiple of 4, range 8..64. Any other value fails elaboration.
- TAG_W, 4, width of the sideband tag carried alongside each beat. Minimum 1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block can accept a beat this cycle
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_cin  input  1  carry-in; used only when in_sub=0
- in_sub  input  1  1 = A-B, 0 = A+B+cin
- in_tag  input  TAG_W  sideband, returned unchanged
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_sum  output  WIDTH  result, modulo 2^WIDTH
- out_cout  output  1  carry out of the MSB. For subtract: 1 = no borrow.
- out_ovf  output  1  signed two's-complement overflow
- out_tag  output  TAG_W  tag of this result

Behaviour:
- Reset:
  - rst_n sampled low at a rising edge clears all stage-valid flags to 0.
  - out_valid=0 and out_sum/out_cout/out_ovf/out_tag=0 from the following cycle.
  - Data registers other than the output stage need not be cleared.
  - Reset mid-operation discards all in-flight beats; none are emitted afterwards.
- Operand conditioning:
  - b_eff = in_sub ? ~in_b : in_b.
  - c0 = in_sub ? 1 : in_cin.
- Stage 1 (S1) registers the following, plus sub/tag/valid:
  - g = a & b_eff, p = a ^ b_eff, c0.
- Stage 2 (S2) registers:
  - Per 4-bit group k: group G_k/P_k and internal carries c[4k+1..4k+3], all relative to a group carry-in of 0 or 1.
  - Inter-group carries C_k, computed by 4-wide lookahead over the groups, recursively for more than 4 groups.
  - Carry into group 0 is c0.
  - Final group carries must equal ripple-carry results.
- Stage 3 (output) registers:
  - sum = p ^ carries.
  - cout = carry out of bit WIDTH-1.
  - ovf = carry into MSB XOR carry out of MSB.
- Handshake:
  - en = ~out_valid | out_ready; in_ready = en (combinational from out_valid, out_ready only).
  - All three stages advance together when en=1 and hold every register when en=0.
  - A beat is accepted at an edge where in_valid & in_ready.
  - If in_valid=0 while en=1, a bubble (valid=0) enters S1.
  - Bubbles are not squeezed out.
- Latency and throughput:
  - A beat accepted at edge k is presented with out_valid=1 after edge k+2, provided en=1 at edges k+1 and k+2. Each stall cycle adds one.
  - Throughput is one beat per cycle with out_ready held 1.
- Stall behaviour: while out_valid=1 and out_ready=0, all out_* signals stay stable and in_ready=0.
- Simultaneous output pop and input accept in the same cycle is legal. No beat is lost or duplicated.
- Results are in order. out_tag always matches the tag of the beat producing out_sum.
- No combinational path from in_a, in_b or in_valid to any output.

Test Plan:
- WIDTH=16, add a=0x7FFF, b=0x0001, cin=0, tag=3 -> after 3 cycles: sum=0x8000, cout=0, ovf=1, tag=3.
- Sub a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0 (borrow), ovf=0. Then a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
- Carry chain across all groups: a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1.
- Back-to-back stream of 100 random beats (WIDTH=32 and 64), out_ready=1 -> one result per cycle, in order, each matching a reference model including cout and ovf.
- Random out_ready toggling at about 50%, in_valid at about 70% -> no loss or duplication, outputs stable while stalled, in_ready==(~out_valid|out_ready) every cycle.
- rst_n low for one cycle while 3 beats are in flight -> out_valid=0 and all outputs 0 next cycle. No stale beat ever appears. First beat after reset returns after 3 cycles.
